seis_c: RTL and testbench

- Registered 4-input / 3-output truth-table classifier.
- Treats inputs {a,b,c,d} as a 4-bit unsigned value N, with a as the MSB, so N ranges 0..15.
- Flags three properties of N: prime, multiple of 3, and out of BCD range.
- Used as a small combinational-decode exercise block. Its registered outputs are sampled once per clock by downstream logic or a waveform dump.

---
 rtl/seis_c.sv | 66 ++++++
 tb/tb_seis_c.sv | 117 +++++++++++
 2 files changed

// File: rtl/seis_c.sv
// seis_c: classifies a 4-bit value N = {a,b,c,d} as prime / multiple of 3 / out of BCD range.
// The flags are registered (1-cycle latency) or, with OUT_REG=0, driven straight from the decode.
module seis_c #(
    parameter int OUT_REG = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic a,
    input  logic b,
    input  logic c,
    input  logic d,
    output logic x,
    output logic y,
    output logic z
);

    logic [3:0] value;
    logic [2:0] flags_d;

    assign value = {a, b, c, d};

    // Flags are packed {prime, multipleOfThree, notBcd}.
    // Unknown inputs fall to the default arm, so they decode to all zeros.
    always_comb begin
        flags_d = 3'b000;
        case (value)
            4'd0:    flags_d = 3'b010;
            4'd1:    flags_d = 3'b000;
            4'd2:    flags_d = 3'b100;
            4'd3:    flags_d = 3'b110;
            4'd4:    flags_d = 3'b000;
            4'd5:    flags_d = 3'b100;
            4'd6:    flags_d = 3'b010;
            4'd7:    flags_d = 3'b100;
            4'd8:    flags_d = 3'b000;
            4'd9:    flags_d = 3'b010;
            4'd10:   flags_d = 3'b001;
            4'd11:   flags_d = 3'b101;
            4'd12:   flags_d = 3'b011;
            4'd13:   flags_d = 3'b101;
            4'd14:   flags_d = 3'b001;
            4'd15:   flags_d = 3'b011;
            default: flags_d = 3'b000;
        endcase
    end

    generate
        if (OUT_REG != 0) begin : gen_registered
            logic [2:0] flags_q;

            // Reset wins over the decode so the flops clear even while inputs are still X.
            always_ff @(posedge clk) begin
                if (rst) begin
                    flags_q <= 3'b000;
                end else begin
                    flags_q <= flags_d;
                end
            end

            assign {x, y, z} = flags_q;
        end else begin : gen_combinational
            assign {x, y, z} = flags_d;
        end
    endgenerate

endmodule

// File: tb/tb_seis_c.sv
// Directed bench for seis_c: reset, sweep of every N, latency, mid-stream reset, boundaries,
// plus a combinational (OUT_REG=0) instance that shares the same inputs.
module tb_seis_c;

    logic clk;
    logic rst;
    logic a, b, c, d;
    logic xReg, yReg, zReg;
    logic xComb, yComb, zComb;

    int testCount = 0;
    int failCount = 0;

    // Expected {x,y,z} for N = 0..15, transcribed by hand from the truth table.
    logic [2:0] expTable [16] = '{
        3'b010, 3'b000, 3'b100, 3'b110,
        3'b000, 3'b100, 3'b010, 3'b100,
        3'b000, 3'b010, 3'b001, 3'b101,
        3'b011, 3'b101, 3'b001, 3'b011
    };

    seis_c #(.OUT_REG(1)) dutReg (
        .clk(clk), .rst(rst),
        .a(a), .b(b), .c(c), .d(d),
        .x(xReg), .y(yReg), .z(zReg)
    );

    seis_c #(.OUT_REG(0)) dutComb (
        .clk(clk), .rst(rst),
        .a(a), .b(b), .c(c), .d(d),
        .x(xComb), .y(yComb), .z(zComb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic applyStimulus(input logic [3:0] n);
        {a, b, c, d} = n;
    endtask

    task automatic checkOutput(input string tag, input logic [2:0] observed, input logic [2:0] expected);
        testCount++;
        assert (observed === expected) else begin
            failCount++;
            $error("[TB] FAIL %s: observed xyz=%b expected xyz=%b", tag, observed, expected);
        end
    endtask

    initial begin
        rst = 1'b1;
        applyStimulus(4'd15);

        // Reset held for two edges with N=15 on the inputs.
        repeat (2) begin
            @(posedge clk); #1;
            checkOutput("reset_hold", {xReg, yReg, zReg}, 3'b000);
        end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        checkOutput("reset_release_n15", {xReg, yReg, zReg}, 3'b011);

        // Sweep every N, with a one-cycle reset pulse injected at N=13.
        for (int n = 0; n < 16; n++) begin
            @(negedge clk);
            applyStimulus(n[3:0]);
            if (n == 13) rst = 1'b1;
            #1;
            checkOutput($sformatf("comb_n%0d", n), {xComb, yComb, zComb}, expTable[n]);
            @(posedge clk); #1;
            if (n == 13) begin
                checkOutput("midstream_reset", {xReg, yReg, zReg}, 3'b000);
                @(negedge clk);
                rst = 1'b0;
                @(posedge clk); #1;
            end
            checkOutput($sformatf("sweep_n%0d", n), {xReg, yReg, zReg}, expTable[n]);
        end

        // Latency: 2 -> 9; the registered outputs must not move until the next edge.
        @(negedge clk);
        applyStimulus(4'd2);
        @(posedge clk); #1;
        checkOutput("latency_n2", {xReg, yReg, zReg}, 3'b100);
        @(negedge clk);
        applyStimulus(4'd9);
        #1;
        checkOutput("latency_hold_before_edge", {xReg, yReg, zReg}, 3'b100);
        @(posedge clk); #1;
        checkOutput("latency_n9", {xReg, yReg, zReg}, 3'b010);

        // Boundary values around the BCD limit and the bottom of the range.
        @(negedge clk);
        applyStimulus(4'd10);
        @(posedge clk); #1;
        checkOutput("boundary_n10", {xReg, yReg, zReg}, 3'b001);
        @(negedge clk);
        applyStimulus(4'd0);
        @(posedge clk); #1;
        checkOutput("boundary_n0", {xReg, yReg, zReg}, 3'b010);
        @(negedge clk);
        applyStimulus(4'd1);
        @(posedge clk); #1;
        checkOutput("boundary_n1", {xReg, yReg, zReg}, 3'b000);

        // Combinational variant reacts within the same time step, between clock edges.
        #2;
        applyStimulus(4'd5);
        #1;
        checkOutput("comb_n5_no_edge", {xComb, yComb, zComb}, 3'b100);
        checkOutput("reg_unchanged_no_edge", {xReg, yReg, zReg}, 3'b000);

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
